// File: rtl/shared_reg_arbiter_pkg.sv
// Shared types and constants for the round-robin register-write arbiter.
package shared_reg_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 8;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_reg_bank.sv
// Single WIDTH-bit storage register with write-enable and async active-low clear.
module reg_bank
  import shared_reg_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter that serialises NREQ requesters onto one shared register,
// one committed write every three cycles.
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      q,
  output logic                  busy
);

  localparam int IW = idx_w(NREQ);

  state_t          state;
  logic [IW-1:0]   last;
  logic [IW-1:0]   win;
  logic [IW-1:0]   pick;
  logic [IW-1:0]   cand;
  logic            found;
  logic            we;
  logic [WIDTH-1:0] wr_data;

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Search starts just past the last committed winner so every active requester gets a turn.
  always_comb begin
    pick  = last;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last) + k) % NREQ);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    wr_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IW'(i)) begin
        wr_data = wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  // The write only happens if the winner still holds its request in GRANT.
  assign we   = (state == GRANT) && req[win];
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      last  <= IW'(NREQ - 1);
      win   <= '0;
      gnt   <= '0;
      ack   <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            win   <= pick;
            gnt   <= onehot(pick);
            state <= GRANT;
          end
        end
        GRANT: begin
          gnt <= '0;
          if (req[win]) begin
            ack   <= onehot(win);
            last  <= win;
            state <= DONE;
          end else begin
            state <= IDLE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          gnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  reg_bank #(.WIDTH(WIDTH)) u_bank (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (we),
    .d       (wr_data),
    .q       (q)
  );

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Scoreboard bench for shared_reg_arbiter: directed requests, expected grants/acks queued.
module tb_shared_reg_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  typedef struct {
    logic [NREQ-1:0]  a;
    logic [WIDTH-1:0] d;
  } exp_t;

  logic                  clk;
  logic                  reset_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      q;
  logic                  busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [NREQ-1:0] exp_gnt[$];
  exp_t            exp_ack[$];

  bit chk_spacing = 0;
  bit have_prev   = 0;
  int prev_cyc    = 0;
  bit prev_ack_nz = 0;

  shared_reg_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .wdata   (wdata),
    .gnt     (gnt),
    .ack     (ack),
    .q       (q),
    .busy    (busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: consumes expectations whenever the DUT shows a grant or an ack.
  always @(negedge clk) begin
    if (gnt != '0) begin
      if (exp_gnt.size() == 0) begin
        check("unexpected_gnt", 32'(gnt), 32'h0);
      end else begin
        check("gnt", 32'(gnt), 32'(exp_gnt.pop_front()));
      end
      if (chk_spacing) begin
        if (have_prev) check("gnt_spacing", 32'(cyc - prev_cyc), 32'd3);
        prev_cyc  = cyc;
        have_prev = 1;
      end
    end
    if (ack != '0) begin
      check("ack_width", 32'(prev_ack_nz), 32'd0);
      if (exp_ack.size() == 0) begin
        check("unexpected_ack", 32'(ack), 32'h0);
      end else begin
        exp_t e;
        e = exp_ack.pop_front();
        check("ack", 32'(ack), 32'(e.a));
        check("q_on_ack", 32'(q), 32'(e.d));
      end
    end
    if ((gnt | ack) != '0) check("gnt_ack_overlap", 32'(gnt & ack), 32'h0);
    prev_ack_nz = |ack;
  end

  task automatic expect_write(input int i, input logic [WIDTH-1:0] d);
    exp_t e;
    logic [NREQ-1:0] oh;
    oh = '0;
    oh[i] = 1'b1;
    e.a = oh;
    e.d = d;
    exp_gnt.push_back(oh);
    exp_ack.push_back(e);
  endtask

  task automatic set_data(input int i, input logic [WIDTH-1:0] d);
    wdata[i*WIDTH +: WIDTH] = d;
  endtask

  // Drive a request pattern until n acks have been seen, then drop all requests.
  task automatic run(input logic [NREQ-1:0] pat, input int n);
    int got;
    got = 0;
    req = pat;
    for (int c = 0; c < 20 * n && got < n; c++) begin
      @(negedge clk);
      if (|ack) got++;
    end
    req = '0;
    if (got < n) check("ack_timeout", 32'(got), 32'(n));
  endtask

  task automatic wait_gnt();
    bit seen;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (|gnt) seen = 1;
    end
    if (!seen) check("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    reset_n = 0;
    req     = '0;
    repeat (2) @(negedge clk);
    check("rst_q", 32'(q), 32'h0);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    reset_n = 1;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    req     = '0;
    wdata   = '0;
    reset_n = 0;
    do_reset();

    // Single request from requester 2
    set_data(2, 8'hA5);
    expect_write(2, 8'hA5);
    run(4'b0100, 1);
    @(negedge clk);
    check("single_busy_after", 32'(busy), 32'h0);
    check("single_q", 32'(q), 32'hA5);

    // All four requesting continuously from a fresh reset
    do_reset();
    set_data(0, 8'h10); set_data(1, 8'h21); set_data(2, 8'h32); set_data(3, 8'h43);
    expect_write(0, 8'h10); expect_write(1, 8'h21); expect_write(2, 8'h32);
    expect_write(3, 8'h43); expect_write(0, 8'h10);
    chk_spacing = 1; have_prev = 0;
    run(4'b1111, 5);
    chk_spacing = 0;
    repeat (2) @(negedge clk);

    // Wrap-around: last=0 -> requester 3 alone, then 0 before 3
    set_data(3, 8'hC3); set_data(0, 8'h0C);
    expect_write(3, 8'hC3);
    run(4'b1000, 1);
    repeat (2) @(negedge clk);
    expect_write(0, 8'h0C); expect_write(3, 8'hC3);
    run(4'b1001, 2);
    repeat (2) @(negedge clk);

    // Withdrawal of requester 1 during GRANT
    set_data(1, 8'hEE); set_data(2, 8'h77);
    exp_gnt.push_back(4'b0010);
    req = 4'b0010;
    wait_gnt();
    req = '0;
    @(negedge clk);
    check("wd_busy", 32'(busy), 32'h0);
    check("wd_ack", 32'(ack), 32'h0);
    check("wd_q", 32'(q), 32'hC3);
    // last still 3, so requester 1 is served ahead of 2
    expect_write(1, 8'hEE); expect_write(2, 8'h77);
    run(4'b0110, 2);
    repeat (2) @(negedge clk);

    // Commit 5A, then reset in the middle of the next GRANT
    set_data(0, 8'h5A);
    expect_write(0, 8'h5A);
    run(4'b0001, 1);
    repeat (2) @(negedge clk);
    check("pre_rst_q", 32'(q), 32'h5A);
    exp_gnt.push_back(4'b0100);
    req = 4'b0100;
    wait_gnt();
    #2 reset_n = 0;
    #1;
    check("arst_q", 32'(q), 32'h0);
    check("arst_gnt", 32'(gnt), 32'h0);
    check("arst_ack", 32'(ack), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    req = '0;
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    set_data(0, 8'h66); set_data(1, 8'h77); set_data(2, 8'h88); set_data(3, 8'h99);
    expect_write(0, 8'h66); expect_write(1, 8'h77);
    expect_write(2, 8'h88); expect_write(3, 8'h99);
    run(4'b1111, 4);
    repeat (2) @(negedge clk);

    // Hold after ack: requesters 0 and 1 alternate
    set_data(0, 8'h01); set_data(1, 8'h02);
    expect_write(0, 8'h01); expect_write(1, 8'h02);
    expect_write(0, 8'h01); expect_write(1, 8'h02);
    chk_spacing = 1; have_prev = 0;
    run(4'b0011, 4);
    chk_spacing = 0;
    repeat (3) @(negedge clk);

    check("gnt_queue_left", 32'(exp_gnt.size()), 32'd0);
    check("ack_queue_left", 32'(exp_ack.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
